// File: rtl/ctrl_pkg.sv
// Shared types for the WISC-S25 pipelined control unit: opcodes, branch
// conditions, per-stage control bundles and the branch-condition evaluator.
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LLB    = 4'hA,
    OP_LHB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    CC_NE = 3'd0,
    CC_EQ = 3'd1,
    CC_GT = 3'd2,
    CC_LT = 3'd3,
    CC_GE = 3'd4,
    CC_LE = 3'd5,
    CC_OV = 3'd6,
    CC_AL = 3'd7
  } cond_e;

  localparam logic [1:0] IMM_ALU    = 2'b00;
  localparam logic [1:0] IMM_MEM    = 2'b01;
  localparam logic [1:0] IMM_BYTE   = 2'b10;
  localparam logic [1:0] IMM_BRANCH = 2'b11;

  localparam int RADDR_W_DEF = 4;

  typedef struct packed {
    logic [3:0] aluOp;
    logic       aluSrc;
    logic [1:0] immSel;
    logic       pcs;
  } ex_ctrl_t;

  typedef struct packed {
    logic memEn;
    logic memWe;
    logic memToReg;
  } mem_ctrl_t;

  typedef struct packed {
    logic                   regWe;
    logic [RADDR_W_DEF-1:0] rd;
  } wb_ctrl_t;

  // zvn is packed {Z, V, N}, matching the committed flag register layout.
  function automatic logic condMet(input cond_e cc, input logic [2:0] zvn);
    logic z, v, n, res;
    {z, v, n} = zvn;
    case (cc)
      CC_NE:   res = !z;
      CC_EQ:   res = z;
      CC_GT:   res = !z && !n;
      CC_LT:   res = n;
      CC_GE:   res = z || (!z && !n);
      CC_LE:   res = n || z;
      CC_OV:   res = v;
      CC_AL:   res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational ID-stage decoder: instruction -> EX/MEM/WB control bundles,
// register-source usage, flag-write mask and branch/halt markers.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int RADDR_W = 4
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic               valid,
  output ex_ctrl_t           exCtrl,
  output mem_ctrl_t          memCtrl,
  output logic               regWe,
  output logic [RADDR_W-1:0] rd,
  output logic               useRs1,
  output logic               useRs2,
  output logic [RADDR_W-1:0] rs1,
  output logic [RADDR_W-1:0] rs2,
  output logic [2:0]         flagWr,
  output logic               isB,
  output logic               isBr,
  output logic               isHlt
);

  opcode_e            op;
  logic [RADDR_W-1:0] fieldA;
  logic [RADDR_W-1:0] fieldB;
  logic [RADDR_W-1:0] fieldC;

  assign op     = opcode_e'(instr[INSTR_W-1 -: 4]);
  assign fieldA = instr[INSTR_W-5 -: RADDR_W];
  assign fieldB = instr[INSTR_W-5-RADDR_W -: RADDR_W];
  assign fieldC = instr[RADDR_W-1:0];

  always_comb begin
    exCtrl  = '0;
    memCtrl = '0;
    regWe   = 1'b0;
    useRs1  = 1'b0;
    useRs2  = 1'b0;
    rs1     = fieldB;
    rs2     = fieldC;
    flagWr  = 3'b000;
    isB     = 1'b0;
    isBr    = 1'b0;
    isHlt   = 1'b0;
    if (valid) begin
      exCtrl.aluOp = op;
      case (op)
        OP_ADD, OP_SUB: begin
          regWe = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1; flagWr = 3'b111;
        end
        OP_XOR: begin
          regWe = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1; flagWr = 3'b100;
        end
        OP_RED, OP_PADDSB: begin
          regWe = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1;
        end
        OP_SLL, OP_SRA, OP_ROR: begin
          regWe = 1'b1; useRs1 = 1'b1; flagWr = 3'b100;
          exCtrl.aluSrc = 1'b1; exCtrl.immSel = IMM_ALU;
        end
        OP_LW: begin
          memCtrl.memEn = 1'b1; memCtrl.memToReg = 1'b1;
          regWe = 1'b1; useRs1 = 1'b1; exCtrl.immSel = IMM_MEM;
        end
        OP_SW: begin
          // Store data register sits in the rd field.
          memCtrl.memEn = 1'b1; memCtrl.memWe = 1'b1;
          useRs1 = 1'b1; useRs2 = 1'b1; rs2 = fieldA; exCtrl.immSel = IMM_MEM;
        end
        OP_LLB, OP_LHB: begin
          regWe = 1'b1; useRs1 = 1'b1; rs1 = fieldA; exCtrl.immSel = IMM_BYTE;
        end
        OP_B:   begin isB = 1'b1; exCtrl.immSel = IMM_BRANCH; end
        OP_BR:  begin isBr = 1'b1; useRs1 = 1'b1; end
        OP_PCS: begin exCtrl.pcs = 1'b1; regWe = 1'b1; end
        OP_HLT: isHlt = 1'b1;
        default: ;
      endcase
    end
    rd = regWe ? fieldA : '0;
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined control unit: registers decoded control through ID/EX, EX/MEM and
// MEM/WB, owns the Z/V/N flags, resolves branches in ID and raises stall/flush.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int INSTR_W  = 16,
  parameter int RADDR_W  = 4,
  parameter int FLAG_FWD = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] id_instr,
  input  logic               id_valid,
  input  logic               ex_z,
  input  logic               ex_v,
  input  logic               ex_n,
  output logic               stall,
  output logic               flush,
  output logic               br_imm_taken,
  output logic               br_reg_taken,
  output logic [7:0]         ex_ctrl,
  output logic [2:0]         mem_ctrl,
  output logic [RADDR_W:0]   wb_ctrl,
  output logic [2:0]         flags,
  output logic               halted
);

  ex_ctrl_t           dEx;
  mem_ctrl_t          dMem;
  logic               dRegWe, dUse1, dUse2, dIsB, dIsBr, dIsHlt;
  logic [RADDR_W-1:0] dRd, dRs1, dRs2;
  logic [2:0]         dFlagWr;

  ctrl_decode #(.INSTR_W(INSTR_W), .RADDR_W(RADDR_W)) uDecode (
    .instr   (id_instr),
    .valid   (id_valid),
    .exCtrl  (dEx),
    .memCtrl (dMem),
    .regWe   (dRegWe),
    .rd      (dRd),
    .useRs1  (dUse1),
    .useRs2  (dUse2),
    .rs1     (dRs1),
    .rs2     (dRs2),
    .flagWr  (dFlagWr),
    .isB     (dIsB),
    .isBr    (dIsBr),
    .isHlt   (dIsHlt)
  );

  ex_ctrl_t           idExCtrl;
  mem_ctrl_t          idExMem, exMemMem;
  logic               idExWe, exMemWe, memWbWe;
  logic [RADDR_W-1:0] idExRd, exMemRd, memWbRd;
  logic [2:0]         idExFlagWr;
  logic               idExHlt, exMemHlt;
  logic [2:0]         flagsQ;
  logic               haltedQ, haltIssued;

  logic       loadUse, flagStall, insertBubble, stallInt, taken;
  logic [2:0] exFlags, fwdMask, brFlags, flagsNext;

  assign exFlags = {ex_z, ex_v, ex_n};

  assign loadUse = idExMem.memToReg && idExWe &&
                   ((dUse1 && (idExRd == dRs1)) || (dUse2 && (idExRd == dRs2)));
  assign flagStall = (FLAG_FWD == 0) && (dIsB || dIsBr) && (idExFlagWr != 3'b000);

  // Once HLT has been issued to EX, IF/ID stays frozen on it and only bubbles follow.
  assign insertBubble = loadUse || flagStall || haltIssued;
  assign stallInt     = insertBubble || dIsHlt;

  assign fwdMask   = (FLAG_FWD != 0) ? idExFlagWr : 3'b000;
  assign brFlags   = (fwdMask & exFlags) | (~fwdMask & flagsQ);
  assign flagsNext = (idExFlagWr & exFlags) | (~idExFlagWr & flagsQ);
  assign taken     = condMet(cond_e'(id_instr[INSTR_W-5 -: 3]), brFlags);

  // Combinational outputs are held quiet while reset is asserted.
  assign stall        = rst_n && stallInt;
  assign br_imm_taken = rst_n && dIsB && taken && !stallInt;
  assign br_reg_taken = rst_n && dIsBr && taken && !stallInt;
  assign flush        = br_imm_taken || br_reg_taken;

  assign ex_ctrl  = idExCtrl;
  assign mem_ctrl = exMemMem;
  assign wb_ctrl  = {memWbWe, memWbRd};
  assign flags    = flagsQ;
  assign halted   = haltedQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idExCtrl   <= '0;
      idExMem    <= '0;
      idExWe     <= 1'b0;
      idExRd     <= '0;
      idExFlagWr <= 3'b000;
      idExHlt    <= 1'b0;
      exMemMem   <= '0;
      exMemWe    <= 1'b0;
      exMemRd    <= '0;
      exMemHlt   <= 1'b0;
      memWbWe    <= 1'b0;
      memWbRd    <= '0;
      flagsQ     <= 3'b000;
      haltedQ    <= 1'b0;
      haltIssued <= 1'b0;
    end else begin
      idExCtrl   <= insertBubble ? '0 : dEx;
      idExMem    <= insertBubble ? '0 : dMem;
      idExWe     <= insertBubble ? 1'b0 : dRegWe;
      idExRd     <= insertBubble ? '0 : dRd;
      idExFlagWr <= insertBubble ? 3'b000 : dFlagWr;
      idExHlt    <= insertBubble ? 1'b0 : dIsHlt;
      exMemMem   <= idExMem;
      exMemWe    <= idExWe;
      exMemRd    <= idExRd;
      exMemHlt   <= idExHlt;
      memWbWe    <= exMemWe;
      memWbRd    <= exMemRd;
      flagsQ     <= flagsNext;
      haltedQ    <= haltedQ || exMemHlt;
      haltIssued <= haltIssued || (dIsHlt && !insertBubble);
    end
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: one instance with EX-flag forwarding and one
// without, driven by the same instruction stream.
module tb_ctrl_pipe;

  logic        clk;
  logic        rstN;
  logic [15:0] idInstr;
  logic        idValid;
  logic        exZ, exV, exN;

  logic       stall, flush, brImm, brReg, halted;
  logic [7:0] exCtrl;
  logic [2:0] memCtrl, flagsQ;
  logic [4:0] wbCtrl;

  logic       stall0, flush0, brImm0, brReg0, halted0;
  logic [7:0] exCtrl0;
  logic [2:0] memCtrl0, flagsQ0;
  logic [4:0] wbCtrl0;

  int total = 0;
  int bad   = 0;

  ctrl_pipe #(.INSTR_W(16), .RADDR_W(4), .FLAG_FWD(1)) dut (
    .clk(clk), .rst_n(rstN), .id_instr(idInstr), .id_valid(idValid),
    .ex_z(exZ), .ex_v(exV), .ex_n(exN),
    .stall(stall), .flush(flush), .br_imm_taken(brImm), .br_reg_taken(brReg),
    .ex_ctrl(exCtrl), .mem_ctrl(memCtrl), .wb_ctrl(wbCtrl), .flags(flagsQ),
    .halted(halted)
  );

  ctrl_pipe #(.INSTR_W(16), .RADDR_W(4), .FLAG_FWD(0)) dut0 (
    .clk(clk), .rst_n(rstN), .id_instr(idInstr), .id_valid(idValid),
    .ex_z(exZ), .ex_v(exV), .ex_n(exN),
    .stall(stall0), .flush(flush0), .br_imm_taken(brImm0), .br_reg_taken(brReg0),
    .ex_ctrl(exCtrl0), .mem_ctrl(memCtrl0), .wb_ctrl(wbCtrl0), .flags(flagsQ0),
    .halted(halted0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] ins, input logic v);
    idInstr = ins;
    idValid = v;
  endtask

  task automatic idle(input int n);
    drive(16'h0000, 1'b0);
    repeat (n) nextCyc();
  endtask

  initial begin
    rstN = 1'b0; idInstr = '0; idValid = 1'b0;
    exZ = 1'b0; exV = 1'b0; exN = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    mid();
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_ex", exCtrl, 8'h00);
    chk("rst_mem", memCtrl, 3'b000);
    chk("rst_wb", wbCtrl, 5'h00);
    chk("rst_flags", flagsQ, 3'b000);
    chk("rst_halted", halted, 0);
    rstN = 1'b1;
    nextCyc();

    // Load-use: LW R4,R5,2 then ADD R6,R4,R7
    drive(16'h8452, 1'b1); mid();
    chk("lu_lw_nostall", stall, 0);
    nextCyc(); drive(16'h0647, 1'b1); mid();
    chk("lu_stall", stall, 1);
    chk("lu_flush", flush, 0);
    chk("lu_ex_lw", exCtrl, 8'h82);
    nextCyc(); mid();
    chk("lu_stall_release", stall, 0);
    chk("lu_ex_bubble", exCtrl, 8'h00);
    chk("lu_mem_lw", memCtrl, 3'b101);
    nextCyc(); drive(16'h0000, 1'b0); mid();
    chk("lu_wb_lw", wbCtrl, 5'h14);
    nextCyc(); mid();
    chk("lu_wb_bubble", wbCtrl, 5'h00);
    nextCyc(); mid();
    chk("lu_wb_add", wbCtrl, 5'h16);

    // Store source from [11:8], LLB no-stall, R0 match still stalls
    idle(2);
    drive(16'h8452, 1'b1);
    nextCyc(); drive(16'h9450, 1'b1); mid();
    chk("sw_src_stall", stall, 1);
    nextCyc(); mid();
    chk("sw_stall_once", stall, 0);
    nextCyc(); drive(16'h0000, 1'b0); mid();
    chk("sw_ex", exCtrl, 8'h92);
    nextCyc(); mid();
    chk("sw_mem", memCtrl, 3'b110);
    nextCyc(); drive(16'h8452, 1'b1);
    nextCyc(); drive(16'hA812, 1'b1); mid();
    chk("llb_nostall", stall, 0);
    nextCyc(); drive(16'h8050, 1'b1); mid();
    chk("llb_ex", exCtrl, 8'hA4);
    nextCyc(); drive(16'h0102, 1'b1); mid();
    chk("r0_stall", stall, 1);
    nextCyc(); drive(16'h0000, 1'b0);

    // Flag-dependent branch: ADD (zero result) then B EQ
    idle(2);
    drive(16'h0123, 1'b1);
    nextCyc(); drive(16'hC204, 1'b1); exZ = 1'b1; mid();
    chk("fwd_taken", brImm, 1);
    chk("fwd_flush", flush, 1);
    chk("fwd_nostall", stall, 0);
    chk("nofwd_stall", stall0, 1);
    chk("nofwd_flush_held", flush0, 0);
    chk("nofwd_br_held", brImm0, 0);
    nextCyc(); exZ = 1'b0; mid();
    chk("nofwd_taken", brImm0, 1);
    chk("nofwd_flush", flush0, 1);
    chk("nofwd_stall_once", stall0, 0);
    chk("eq_flags", flagsQ, 3'b100);
    chk("eq_flags0", flagsQ0, 3'b100);
    nextCyc(); drive(16'hC004, 1'b1); mid();
    chk("ne_not_taken", brImm, 0);
    chk("ne_no_flush", flush, 0);

    // Flag-write scope: SUB sets Z,V; XOR rewrites Z only; LW touches nothing
    nextCyc(); drive(16'h1123, 1'b1);
    nextCyc(); drive(16'h0000, 1'b0); exZ = 1'b1; exV = 1'b1; exN = 1'b0;
    nextCyc(); exZ = 1'b0; exV = 1'b0; drive(16'h2123, 1'b1); mid();
    chk("sub_flags", flagsQ, 3'b110);
    nextCyc(); drive(16'h0000, 1'b0); exN = 1'b1;
    nextCyc(); exN = 1'b0; mid();
    chk("xor_scope", flagsQ, 3'b010);
    drive(16'h8452, 1'b1);
    nextCyc(); drive(16'h0000, 1'b0); exZ = 1'b1; exN = 1'b1;
    nextCyc(); exZ = 1'b0; exN = 1'b0; mid();
    chk("lw_keeps_flags", flagsQ, 3'b010);
    drive(16'hCC00, 1'b1); mid();
    chk("ov_taken", brImm, 1);
    nextCyc(); drive(16'hDE20, 1'b1); mid();
    chk("br_reg_taken", brReg, 1);
    chk("br_reg_not_imm", brImm, 0);
    chk("br_reg_flush", flush, 1);

    // Halt
    nextCyc(); idle(2);
    drive(16'hF000, 1'b1); mid();
    chk("hlt_stall", stall, 1);
    nextCyc(); mid();
    chk("hlt_ex", exCtrl, 8'hF0);
    chk("hlt_not_yet", halted, 0);
    nextCyc(); mid();
    chk("hlt_bubble", exCtrl, 8'h00);
    chk("hlt_not_yet2", halted, 0);
    nextCyc(); mid();
    chk("halted_rise", halted, 1);
    repeat (20) nextCyc();
    mid();
    chk("halted_sticky", halted, 1);
    chk("hlt_stall_held", stall, 1);

    // Asynchronous reset between edges
    #2 rstN = 1'b0;
    #1;
    chk("arst_stall", stall, 0);
    chk("arst_halted", halted, 0);
    chk("arst_flags", flagsQ, 3'b000);
    chk("arst_ex", exCtrl, 8'h00);
    chk("arst_wb", wbCtrl, 5'h00);
    drive(16'h0000, 1'b0);
    @(posedge clk); #3 rstN = 1'b1;
    nextCyc();
    drive(16'h0647, 1'b1);
    nextCyc(); drive(16'h0000, 1'b0);
    nextCyc(); mid();
    chk("post_rst_wb_early", wbCtrl, 5'h00);
    nextCyc(); mid();
    chk("post_rst_wb", wbCtrl, 5'h16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Pipelined control unit for the WISC-S25 5-stage core (IF/ID/EX/MEM/WB).
- Decodes the ID-stage instruction into control bundles and registers them through ID/EX, EX/MEM and MEM/WB.
- Owns the Z/V/N flag register and resolves B/BR conditions in ID.
- Detects load-use and flag hazards and issues stall/flush; latches HLT into a sticky halted state.

Parameters:
- INSTR_W, 16, instruction width; opcode is always the top 4 bits.
- RADDR_W, 4, register address width.
- FLAG_FWD, 1, 1 = forward EX-stage flags to branch evaluation; 0 = stall the branch until those flags commit.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_instr  in  INSTR_W  instruction in IF/ID
- id_valid  in  1  IF/ID holds a real instruction
- ex_z, ex_v, ex_n  in  1 each  flags computed by the ALU this cycle for the EX instruction
- stall  out  1  hold PC and IF/ID; bubble inserted into ID/EX
- flush  out  1  squash IF/ID (taken branch)
- br_imm_taken  out  1  take PC+2+(sext(imm9)<<1)
- br_reg_taken  out  1  take PC <- rs data
- ex_ctrl  out  8  {alu_op[3:0], alusrc, imm_sel[1:0], pcs}
- mem_ctrl  out  3  {mem_en, mem_we, mem_to_reg}
- wb_ctrl  out  1+RADDR_W  {reg_we, rd}
- flags  out  3  committed {Z, V, N}
- halted  out  1  HLT has reached WB (sticky)

Behaviour:
- Reset (async, rst_n=0): all pipeline control registers cleared to a bubble (all enables 0); flags=3'b000; halted=0; stall=flush=br_*=0.
- Decode, combinational in ID:
  - R-type 0000–0011, 0111: reg_we=1, alusrc=0.
  - 0100–0110: alusrc=1, imm_sel=00.
  - LW 1000: mem_en=1, mem_to_reg=1, reg_we=1, imm_sel=01.
  - SW 1001: mem_en=1, mem_we=1, imm_sel=01, rs2 taken from [11:8].
  - LLB/LHB 101x: reg_we=1, imm_sel=10, rs1 taken from [11:8].
  - B 1100: imm_sel=11.
  - PCS 1110: pcs=1, reg_we=1.
  - HLT 1111: no writes.
  - id_valid=0 decodes as a bubble.
- Flag writes, applied on the EX-stage cycle edge:
  - ADD/SUB write Z, V, N.
  - XOR/SLL/SRA/ROR write Z only.
  - All other opcodes leave flags unchanged.
- Branch conditions (ccc = instr[11:9]):
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | (!Z & !N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111: always
- Flag source for branch evaluation:
  - If the EX instruction writes flags and FLAG_FWD=1: use the EX flags merged with committed flags, per written bit.
  - If FLAG_FWD=0: assert stall for 1 cycle instead.
- Branch outcome, combinational in the same cycle:
  - Taken: br_*_taken=1 and flush=1.
  - Not taken: no effect.
- Load-use hazard: EX holds LW with reg_we and rd matches a used ID source (rs1 or rs2, per opcode) -> stall=1 for exactly 1 cycle and a bubble into ID/EX. A match on rd=R0 still stalls.
- Stall and branch priority: while stall=1, branch outputs and flush are forced 0; the branch is re-evaluated next cycle.
- Stall and flush are never both 1.
- HLT handling:
  - Decoded in ID: stall stays 1 from that cycle on; IF/ID is frozen holding HLT and bubbles are issued behind it.
  - HLT itself advances to EX on the first cycle, so it does drain.
  - When HLT reaches MEM/WB: halted=1 on the next edge; it stays 1 until reset.
- Pipeline advance: ID/EX <- decode, or a bubble on stall. EX/MEM and MEM/WB always advance; there is no back-pressure from MEM.
- Latency:
  - ex_ctrl is valid 1 cycle after ID.
  - mem_ctrl is valid 2 cycles after ID.
  - wb_ctrl is valid 3 cycles after ID.
- Reset mid-operation: the pipeline empties immediately and flags clear; in-flight stores are dropped.

Decomposition:
- Package ctrl_pkg:
  - opcode enum: ADD, SUB, XOR, RED, SLL, SRA, ROR, PADDSB, LW, SW, LLB, LHB, B, BR, PCS, HLT.
  - cond enum.
  - packed structs ex_ctrl_t, mem_ctrl_t, wb_ctrl_t.
  - imm_sel constants.
- Sub-module ctrl_decode: purely combinational opcode -> bundles plus source-use flags. The pipeline registers, hazard logic, flag register and branch evaluation stay in ctrl_pipe.

Test Plan:
- Flag-dependent branch, FLAG_FWD=1: ADD R1,R2,R3 (result 0) then B EQ -> br_imm_taken=1 and flush=1 in the same cycle as the ADD is in EX. With FLAG_FWD=0 -> stall=1 for 1 cycle, then taken.
- Load-use: LW R4,R5,2 then ADD R6,R4,R7 -> stall=1 for exactly 1 cycle; ex_ctrl is a bubble; ADD reaches EX one cycle late.
- Store source check: LW R4 then SW R4,R5,0 (R4 as [11:8] source) -> stall 1 cycle. LW R4 then LLB R8 -> no stall.
- Flag-write scope: XOR producing a nonzero result with a prior V=1 -> Z=0 and V stays 1. LW leaves flags unchanged. BR with ccc=111 -> br_reg_taken=1.
- Halt: HLT issued -> stall held high; halted rises 3 cycles later and stays high across 20 idle cycles.
- Reset: assert rst_n=0 mid-sequence asynchronously (between clock edges) -> all outputs return to reset values immediately; after release, the first ADD produces wb_ctrl.reg_we=1 three cycles after ID.
